// File: rtl/vc_fifo_bank_if.sv
// Shared write/read ports and per-channel status of the virtual-channel FIFO bank.
interface vc_fifo_bank_if #(
   parameter int unsigned DATA_WIDTH   = 6,
   parameter int unsigned ADDR_WIDTH   = 2,
   parameter int unsigned VC_SEL_WIDTH = 1
);
   localparam int unsigned NUM_VC = 2 ** VC_SEL_WIDTH;
   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

   logic                      wr_enable;
   logic [VC_SEL_WIDTH-1:0]   wr_vc;
   logic [DATA_WIDTH-1:0]     data_in;
   logic                      rd_enable;
   logic [VC_SEL_WIDTH-1:0]   rd_vc;
   logic [CNT_W-1:0]          umbral_almost_full;
   logic [CNT_W-1:0]          umbral_almost_empty;
   logic [DATA_WIDTH-1:0]     data_out;
   logic                      valid_out;
   logic [NUM_VC-1:0]         full_fifo;
   logic [NUM_VC-1:0]         empty_fifo;
   logic [NUM_VC-1:0]         almost_full_fifo;
   logic [NUM_VC-1:0]         almost_empty_fifo;
   logic [NUM_VC-1:0]         error_vc;
   logic [NUM_VC*CNT_W-1:0]   fifo_count;

   modport master (
      output wr_enable, wr_vc, data_in, rd_enable, rd_vc,
             umbral_almost_full, umbral_almost_empty,
      input  data_out, valid_out, full_fifo, empty_fifo,
             almost_full_fifo, almost_empty_fifo, error_vc, fifo_count
   );

   modport slave (
      input  wr_enable, wr_vc, data_in, rd_enable, rd_vc,
             umbral_almost_full, umbral_almost_empty,
      output data_out, valid_out, full_fifo, empty_fifo,
             almost_full_fifo, almost_empty_fifo, error_vc, fifo_count
   );
endinterface

// File: rtl/vc_fifo_bank.sv
// Bank of independent virtual-channel FIFOs sharing one write port and one read port,
// with per-channel count, full/empty, programmable almost-full/empty and sticky error status.
module vc_fifo_bank #(
   parameter int unsigned DATA_WIDTH   = 6,
   parameter int unsigned ADDR_WIDTH   = 2,
   parameter int unsigned VC_SEL_WIDTH = 1
) (
   input  logic          clk,
   input  logic          reset,
   vc_fifo_bank_if.slave bus
);
   localparam int unsigned NUM_VC = 2 ** VC_SEL_WIDTH;
   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [NUM_VC][DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [NUM_VC][DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q [NUM_VC];
   logic [ADDR_WIDTH-1:0] wr_ptr_d [NUM_VC];
   logic [ADDR_WIDTH-1:0] rd_ptr_q [NUM_VC];
   logic [ADDR_WIDTH-1:0] rd_ptr_d [NUM_VC];
   logic [CNT_W-1:0]      cnt_q [NUM_VC];
   logic [CNT_W-1:0]      cnt_d [NUM_VC];
   logic [NUM_VC-1:0]     error_q, error_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;

   logic [NUM_VC-1:0]       full_c, empty_c, almost_full_c, almost_empty_c;
   logic [NUM_VC*CNT_W-1:0] fifo_count_c;
   logic [CNT_W-1:0]        af_level_c;
   logic                    af_sat_c;
   logic                    wr_acc_c, rd_acc_c;
   logic                    inc_c, dec_c;

   // Status decode from registered counts; a threshold above DEPTH forces almost_full high.
   always_comb begin
      full_c         = '0;
      empty_c        = '0;
      almost_full_c  = '0;
      almost_empty_c = '0;
      fifo_count_c   = '0;
      af_sat_c       = bus.umbral_almost_full > CNT_W'(DEPTH);
      af_level_c     = CNT_W'(DEPTH) - bus.umbral_almost_full;
      for (int i = 0; i < int'(NUM_VC); i++) begin
         full_c[i]         = cnt_q[i] == CNT_W'(DEPTH);
         empty_c[i]        = cnt_q[i] == '0;
         almost_full_c[i]  = af_sat_c || (cnt_q[i] >= af_level_c);
         almost_empty_c[i] = cnt_q[i] <= bus.umbral_almost_empty;
         fifo_count_c[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   // Acceptance: a full channel still takes a write when it is read in the same cycle.
   always_comb begin
      rd_acc_c = bus.rd_enable && !empty_c[bus.rd_vc];
      wr_acc_c = bus.wr_enable &&
                 (!full_c[bus.wr_vc] || (rd_acc_c && (bus.rd_vc == bus.wr_vc)));
   end

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      error_d     = error_q;
      inc_c       = 1'b0;
      dec_c       = 1'b0;
      data_out_d  = '0;
      valid_out_d = rd_acc_c;

      if (wr_acc_c) begin
         mem_d[bus.wr_vc][wr_ptr_q[bus.wr_vc]] = bus.data_in;
      end
      if (rd_acc_c) begin
         data_out_d = mem_q[bus.rd_vc][rd_ptr_q[bus.rd_vc]];
      end
      if (bus.wr_enable && !wr_acc_c) begin
         error_d[bus.wr_vc] = 1'b1;
      end
      if (bus.rd_enable && !rd_acc_c) begin
         error_d[bus.rd_vc] = 1'b1;
      end

      for (int i = 0; i < int'(NUM_VC); i++) begin
         inc_c = wr_acc_c && (bus.wr_vc == VC_SEL_WIDTH'(i));
         dec_c = rd_acc_c && (bus.rd_vc == VC_SEL_WIDTH'(i));
         if (inc_c) begin
            wr_ptr_d[i] = wr_ptr_q[i] + ADDR_WIDTH'(1);
         end
         if (dec_c) begin
            rd_ptr_d[i] = rd_ptr_q[i] + ADDR_WIDTH'(1);
         end
         if (inc_c && !dec_c) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec_c && !inc_c) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '{default: '0};
         rd_ptr_q    <= '{default: '0};
         cnt_q       <= '{default: '0};
         error_q     <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         error_q     <= error_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   // Storage is never cleared; a write arriving with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= mem_d;
      end
   end

   assign bus.data_out          = data_out_q;
   assign bus.valid_out         = valid_out_q;
   assign bus.full_fifo         = full_c;
   assign bus.empty_fifo        = empty_c;
   assign bus.almost_full_fifo  = almost_full_c;
   assign bus.almost_empty_fifo = almost_empty_c;
   assign bus.error_vc          = error_q;
   assign bus.fifo_count        = fifo_count_c;
endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed self-checking bench for vc_fifo_bank: reset, fill/drain, overflow, underflow,
// simultaneous operations, thresholds and pointer wrap.
module tb_vc_fifo_bank;
   localparam int unsigned DW = 6;
   localparam int unsigned AW = 2;
   localparam int unsigned VW = 1;
   localparam int unsigned CW = AW + 1;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   vc_fifo_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VC_SEL_WIDTH(VW)) bus ();

   vc_fifo_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VC_SEL_WIDTH(VW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [CW-1:0] cnt(input int v);
      return bus.fifo_count[v*CW +: CW];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic we, input logic [VW-1:0] wv, input logic [DW-1:0] d,
                     input logic re, input logic [VW-1:0] rv);
      bus.wr_enable = we;
      bus.wr_vc     = wv;
      bus.data_in   = d;
      bus.rd_enable = re;
      bus.rd_vc     = rv;
      step();
      bus.wr_enable = 1'b0;
      bus.rd_enable = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++;
      if (bus.empty_fifo !== 2'b11) begin
         failures++; $display("FAIL reset_empty got=%b exp=%b", bus.empty_fifo, 2'b11);
      end
      checks++;
      if (bus.full_fifo !== 2'b00) begin
         failures++; $display("FAIL reset_full got=%b exp=%b", bus.full_fifo, 2'b00);
      end
      checks++;
      if (bus.error_vc !== 2'b00) begin
         failures++; $display("FAIL reset_error got=%b exp=%b", bus.error_vc, 2'b00);
      end
      checks++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h00) begin
         failures++; $display("FAIL reset_out got=%b/%h exp=0/00", bus.valid_out, bus.data_out);
      end
      checks++;
      if (bus.fifo_count !== 6'b000000) begin
         failures++; $display("FAIL reset_count got=%b exp=000000", bus.fifo_count);
      end
      checks++;
      if (bus.almost_empty_fifo !== 2'b11 || bus.almost_full_fifo !== 2'b00) begin
         failures++; $display("FAIL reset_almost got=ae%b/af%b exp=ae11/af00",
                              bus.almost_empty_fifo, bus.almost_full_fifo);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
      checks++;
      if (bus.full_fifo !== 2'b01 || cnt(0) !== 3'd4) begin
         failures++; $display("FAIL fill_full got=%b cnt=%0d exp=01 cnt=4", bus.full_fifo, cnt(0));
      end
      checks++;
      if (bus.empty_fifo !== 2'b10 || bus.almost_full_fifo !== 2'b01) begin
         failures++; $display("FAIL fill_status got=e%b/af%b exp=e10/af01",
                              bus.empty_fifo, bus.almost_full_fifo);
      end
      for (int i = 1; i <= 4; i++) begin
         op(1'b0, 1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== DW'(i)) begin
            failures++; $display("FAIL drain_data%0d got=%b/%h exp=1/%h", i,
                                 bus.valid_out, bus.data_out, DW'(i));
         end
      end
      checks++;
      if (bus.empty_fifo !== 2'b11 || cnt(0) !== 3'd0) begin
         failures++; $display("FAIL drain_empty got=%b cnt=%0d exp=11 cnt=0", bus.empty_fifo, cnt(0));
      end
      op(1'b0, 1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h00) begin
         failures++; $display("FAIL idle_out got=%b/%h exp=0/00", bus.valid_out, bus.data_out);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) op(1'b1, 1'b1, DW'(17 + i), 1'b0, 1'b0);
      op(1'b1, 1'b1, 6'h3F, 1'b0, 1'b0);
      checks++;
      if (bus.error_vc !== 2'b10 || cnt(1) !== 3'd4) begin
         failures++; $display("FAIL overflow got=err%b cnt=%0d exp=err10 cnt=4", bus.error_vc, cnt(1));
      end
      for (int i = 0; i < 4; i++) begin
         op(1'b0, 1'b0, '0, 1'b1, 1'b1);
         checks++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== DW'(17 + i)) begin
            failures++; $display("FAIL overflow_data%0d got=%b/%h exp=1/%h", i,
                                 bus.valid_out, bus.data_out, DW'(17 + i));
         end
      end
   endtask

   task automatic test_underflow();
      op(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h00) begin
         failures++; $display("FAIL underflow_out got=%b/%h exp=0/00", bus.valid_out, bus.data_out);
      end
      checks++;
      if (bus.error_vc !== 2'b11 || cnt(0) !== 3'd0) begin
         failures++; $display("FAIL underflow got=err%b cnt=%0d exp=err11 cnt=0", bus.error_vc, cnt(0));
      end
   endtask

   task automatic test_simultaneous();
      op(1'b1, 1'b0, 6'h2A, 1'b0, 1'b0);
      op(1'b1, 1'b0, 6'h2B, 1'b0, 1'b0);
      // Reset with a write pending: stored words and the request are discarded.
      bus.wr_enable = 1'b1; bus.wr_vc = 1'b0; bus.data_in = 6'h2C;
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.wr_enable = 1'b0;
      checks++;
      if (cnt(0) !== 3'd0 || bus.error_vc !== 2'b00 || bus.empty_fifo !== 2'b11) begin
         failures++; $display("FAIL midreset got=cnt%0d err%b e%b exp=cnt0 err00 e11",
                              cnt(0), bus.error_vc, bus.empty_fifo);
      end
      for (int i = 0; i < 4; i++) op(1'b1, 1'b0, DW'(33 + i), 1'b0, 1'b0);
      op(1'b1, 1'b0, 6'h25, 1'b1, 1'b0);
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 6'h21 || cnt(0) !== 3'd4 ||
          bus.error_vc !== 2'b00) begin
         failures++; $display("FAIL full_wr_rd got=%b/%h cnt=%0d err=%b exp=1/21 cnt=4 err=00",
                              bus.valid_out, bus.data_out, cnt(0), bus.error_vc);
      end
      op(1'b1, 1'b1, 6'h30, 1'b1, 1'b0);
      checks++;
      if (bus.data_out !== 6'h22 || cnt(0) !== 3'd3 || cnt(1) !== 3'd1) begin
         failures++; $display("FAIL cross_vc got=%h cnt0=%0d cnt1=%0d exp=22 cnt0=3 cnt1=1",
                              bus.data_out, cnt(0), cnt(1));
      end
      for (int i = 0; i < 3; i++) begin
         op(1'b0, 1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== DW'(35 + i)) begin
            failures++; $display("FAIL sim_drain%0d got=%b/%h exp=1/%h", i,
                                 bus.valid_out, bus.data_out, DW'(35 + i));
         end
      end
      op(1'b0, 1'b0, '0, 1'b1, 1'b1);
      checks++;
      if (bus.data_out !== 6'h30 || bus.empty_fifo !== 2'b11) begin
         failures++; $display("FAIL sim_vc1 got=%h e=%b exp=30 e=11", bus.data_out, bus.empty_fifo);
      end
   endtask

   task automatic test_thresholds_wrap();
      logic [DW-1:0] v;
      logic          af_exp, ae_exp;
      bus.umbral_almost_full  = 3'd1;
      bus.umbral_almost_empty = 3'd1;
      for (int k = 0; k < 10; k++) begin
         v = DW'(k * 5 + 3);
         op(1'b1, 1'b1, v, 1'b0, 1'b0);
         checks++;
         if (cnt(1) !== 3'd1 || bus.almost_empty_fifo[1] !== 1'b1 || bus.almost_full_fifo[1] !== 1'b0) begin
            failures++; $display("FAIL wrap_status%0d got=cnt%0d ae%b af%b exp=cnt1 ae1 af0", k,
                                 cnt(1), bus.almost_empty_fifo[1], bus.almost_full_fifo[1]);
         end
         op(1'b0, 1'b0, '0, 1'b1, 1'b1);
         checks++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== v) begin
            failures++; $display("FAIL wrap_data%0d got=%b/%h exp=1/%h", k,
                                 bus.valid_out, bus.data_out, v);
         end
      end
      for (int n = 1; n <= 4; n++) begin
         op(1'b1, 1'b1, DW'(40 + n), 1'b0, 1'b0);
         af_exp = (n >= 3);
         ae_exp = (n <= 1);
         checks++;
         if (bus.almost_full_fifo[1] !== af_exp || bus.almost_empty_fifo[1] !== ae_exp) begin
            failures++; $display("FAIL thresh_cnt%0d got=af%b ae%b exp=af%b ae%b", n,
                                 bus.almost_full_fifo[1], bus.almost_empty_fifo[1], af_exp, ae_exp);
         end
      end
      bus.umbral_almost_full  = 3'd7;
      bus.umbral_almost_empty = 3'd5;
      #1;
      checks++;
      if (bus.almost_full_fifo !== 2'b11 || bus.almost_empty_fifo !== 2'b11) begin
         failures++; $display("FAIL saturate got=af%b ae%b exp=af11 ae11",
                              bus.almost_full_fifo, bus.almost_empty_fifo);
      end
      bus.umbral_almost_full  = 3'd0;
      bus.umbral_almost_empty = 3'd0;
      for (int n = 1; n <= 4; n++) begin
         op(1'b0, 1'b0, '0, 1'b1, 1'b1);
         checks++;
         if (bus.data_out !== DW'(40 + n)) begin
            failures++; $display("FAIL thresh_drain%0d got=%h exp=%h", n, bus.data_out, DW'(40 + n));
         end
      end
   endtask

   initial begin
      reset                   = 1'b1;
      bus.wr_enable           = 1'b0;
      bus.wr_vc               = '0;
      bus.data_in             = '0;
      bus.rd_enable           = 1'b0;
      bus.rd_vc               = '0;
      bus.umbral_almost_full  = 3'd0;
      bus.umbral_almost_empty = 3'd0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_simultaneous();
      test_thresholds_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
